// File: rtl/serial_regfile_pkg.sv
// serial_regfile_pkg: shared FSM states, frame-width helper and RW encodings
package serial_regfile_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ACK, DATA, DONE, IGNORE} state_t;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    function automatic int cmd_width(input int addr_w, input int idx_w);
        return addr_w + 1 + idx_w;
    endfunction
endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: LSB-first shifter; new bits enter at the MSB, shift_out is the LSB
// Ports: clk, rst (sync, active-high), load/load_val (parallel load, wins over shift),
//        shift/shift_in (serial shift right), shift_out (q[0]), q (parallel contents)
module serial_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         shift_in,
    output logic         shift_out,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (load) q <= load_val;
        else if (shift) q <= {shift_in, q[W-1:1]};
    end
    assign shift_out = q[0];
endmodule

// File: rtl/serial_regfile_slave.sv
// serial_regfile_slave: single-wire addressed register-file target on a shared RX/SEL bus
// Ports: CLK, RST (sync, active-high), SEL (frame select), RX (serial in, LSB first),
//        DEV_ADDR (strapped address), TX/TX_EN (serial out, idles high), BUSY (addressed),
//        WR_STROBE (pulse after commit), REG_OUT (flattened registers),
//        PARITY_ERR (sticky, only with SERIAL_REGFILE_PARITY_EN defined)
// Build option: define SERIAL_REGFILE_PARITY_EN to add an even-parity bit after the data field.
module serial_regfile_slave
    import serial_regfile_pkg::*;
#(
    parameter int                DEV_ADDR_W = 7,
    parameter int                IDX_W      = 2,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          SEL,
    input  logic                          RX,
    input  logic [DEV_ADDR_W-1:0]         DEV_ADDR,
    output logic                          TX,
    output logic                          TX_EN,
    output logic                          BUSY,
    output logic                          WR_STROBE,
    output logic [(2**IDX_W)*DATA_W-1:0]  REG_OUT
`ifdef SERIAL_REGFILE_PARITY_EN
    ,
    output logic                          PARITY_ERR
`endif
);
    localparam int NUM_REGS = 2**IDX_W;
    localparam int CMD_W    = cmd_width(DEV_ADDR_W, IDX_W);
`ifdef SERIAL_REGFILE_PARITY_EN
    localparam int DATA_LEN = DATA_W + 1;
`else
    localparam int DATA_LEN = DATA_W;
`endif
    localparam int CNT_W    = $clog2(CMD_W + DATA_LEN + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] dat_q;
    logic [CMD_W-1:0]  cmd_next;
    logic [DATA_W-1:0] dat_next;
    logic              cmd_lsb;
    logic              dat_lsb;
    logic              rw;
    logic [IDX_W-1:0]  idx;
    logic              cmd_shift;
    logic              dat_load;
    logic              dat_shift;
    logic              unused;

    // Command is judged on the edge that samples its last bit, so the ACK slot
    // follows immediately; hence the look-ahead values including RX.
    assign cmd_next  = {RX, cmd_q[CMD_W-1:1]};
    assign dat_next  = {RX, dat_q[DATA_W-1:1]};
    assign rw        = cmd_q[DEV_ADDR_W];
    assign idx       = cmd_q[CMD_W-1 -: IDX_W];
    assign cmd_shift = SEL && (state == IDLE || state == CMD);
    assign dat_load  = SEL && state == ACK && rw == RW_READ;
    assign dat_shift = SEL && state == DATA && cnt < CNT_W'(DATA_W);
    assign unused    = ^{cmd_lsb, dat_lsb, cmd_q[0], dat_q[0]};

    serial_shift_reg #(.W(CMD_W)) u_cmd (
        .clk(CLK), .rst(RST), .load(1'b0), .load_val('0), .shift(cmd_shift),
        .shift_in(RX), .shift_out(cmd_lsb), .q(cmd_q)
    );

    serial_shift_reg #(.W(DATA_W)) u_dat (
        .clk(CLK), .rst(RST), .load(dat_load), .load_val(regs[idx]), .shift(dat_shift),
        .shift_in(RX), .shift_out(dat_lsb), .q(dat_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            TX        <= 1'b1;
            TX_EN     <= 1'b0;
            BUSY      <= 1'b0;
            WR_STROBE <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
`ifdef SERIAL_REGFILE_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
        end else if (!SEL) begin
            state     <= IDLE;
            cnt       <= '0;
            TX        <= 1'b1;
            TX_EN     <= 1'b0;
            BUSY      <= 1'b0;
            WR_STROBE <= 1'b0;
        end else begin
            WR_STROBE <= 1'b0;
            case (state)
                IDLE: begin
                    state <= CMD;
                    cnt   <= CNT_W'(1);
                end
                CMD: begin
                    if (cnt == CNT_W'(CMD_W - 1)) begin
                        cnt <= '0;
                        if (cmd_next[DEV_ADDR_W-1:0] == DEV_ADDR) begin
                            state <= ACK;
                            TX    <= 1'b0;
                            TX_EN <= 1'b1;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    state <= DATA;
                    cnt   <= '0;
                    TX    <= (rw == RW_READ) ? regs[idx][0] : 1'b1;
                    TX_EN <= (rw == RW_READ);
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_LEN - 1)) begin
                        state <= DONE;
                        TX    <= 1'b1;
                        TX_EN <= 1'b0;
                        BUSY  <= 1'b0;
                        if (rw == RW_WRITE) begin
`ifdef SERIAL_REGFILE_PARITY_EN
                            if (^{dat_q, RX} == 1'b0) begin
                                regs[idx] <= dat_q;
                                WR_STROBE <= 1'b1;
                            end else begin
                                PARITY_ERR <= 1'b1;
                            end
`else
                            regs[idx] <= dat_next;
                            WR_STROBE <= 1'b1;
`endif
                        end
                    end else if (rw == RW_READ) begin
`ifdef SERIAL_REGFILE_PARITY_EN
                        TX <= (cnt == CNT_W'(DATA_W - 1)) ? ^regs[idx] : dat_q[1];
`else
                        TX <= dat_q[1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign REG_OUT[g*DATA_W +: DATA_W] = regs[g];
    end
endmodule

// File: tb/tb_serial_regfile_slave.sv
// tb_serial_regfile_slave: directed multi-drop bench, four targets on one RX/SEL bus
module tb_serial_regfile_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rx;
    logic [3:0]  tx;
    logic [3:0]  tx_en;
    logic [3:0]  busy;
    logic [3:0]  wr;
    logic [31:0] reg_out [4];
    logic [6:0]  addrs [4] = '{7'h1A, 7'h1B, 7'h2A, 7'h2B};
    logic [7:0]  ab;
`ifdef SERIAL_REGFILE_PARITY_EN
    logic [3:0]  pe;
    logic [7:0]  bd;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_regfile_slave #(
            .DEV_ADDR_W(7), .IDX_W(2), .DATA_W(8), .RESET_VAL(8'h00)
        ) u (
            .CLK(clk), .RST(rst), .SEL(sel), .RX(rx), .DEV_ADDR(addrs[g]),
            .TX(tx[g]), .TX_EN(tx_en[g]), .BUSY(busy[g]), .WR_STROBE(wr[g]),
            .REG_OUT(reg_out[g])
`ifdef SERIAL_REGFILE_PARITY_EN
            , .PARITY_ERR(pe[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [1:0] idx);
        logic [9:0] c;
        c = {idx, rw, a};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = 1'b1;
            rx  = c[i];
        end
    endtask

    task automatic do_write(input int k, input logic [1:0] idx, input logic [7:0] d,
                            input logic [31:0] exp_regs);
        send_cmd(addrs[k], 1'b0, idx);
        @(negedge clk);
        check("wr_ack_tx", 32'(&tx), 32'd0);
        check("wr_ack_en", 32'(tx_en), 32'(1 << k));
        check("wr_ack_busy", 32'(busy), 32'(1 << k));
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wr_data_en", 32'(tx_en), 32'd0);
            rx = d[i];
        end
`ifdef SERIAL_REGFILE_PARITY_EN
        @(negedge clk);
        rx = ^d;
`endif
        @(negedge clk);
        check("wr_strobe", 32'(wr), 32'(1 << k));
        check("wr_regs", reg_out[k], exp_regs);
        check("wr_busy_done", 32'(busy), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        check("wr_strobe_off", 32'(wr), 32'd0);
    endtask

    task automatic do_read(input int k, input logic [1:0] idx, input logic [7:0] e);
        send_cmd(addrs[k], 1'b1, idx);
        @(negedge clk);
        check("rd_ack_tx", 32'(&tx), 32'd0);
        check("rd_ack_en", 32'(tx_en), 32'(1 << k));
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rd_bit", 32'(&tx), 32'(e[i]));
            check("rd_en", 32'(tx_en), 32'(1 << k));
        end
`ifdef SERIAL_REGFILE_PARITY_EN
        @(negedge clk);
        check("rd_parity", 32'(&tx), 32'(^e));
`endif
        @(negedge clk);
        check("rd_done_en", 32'(tx_en), 32'd0);
        check("rd_done_busy", 32'(busy), 32'd0);
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'hF);
        check("rst_en", 32'(tx_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr), 32'd0);
        for (int k = 0; k < 4; k++) check("rst_regs", reg_out[k], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_write(0, 2'd2, 8'h5D, 32'h005D0000);
        check("wr_others", reg_out[1], 32'd0);
        do_read(0, 2'd2, 8'h5D);

        do_write(1, 2'd1, 8'hA5, 32'h0000A500);
        check("mismatch_regs", reg_out[0], 32'h005D0000);

        ab = 8'hC3;
        send_cmd(addrs[0], 1'b0, 2'd1);
        @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx = ab[i];
        end
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobe", 32'(wr), 32'd0);
        check("abort_regs", reg_out[0], 32'h005D0000);
        @(negedge clk);
        check("abort_strobe2", 32'(wr), 32'd0);
        do_write(0, 2'd3, 8'h77, 32'h775D0000);

        do_write(0, 2'd0, 8'h5D, 32'h775D005D);
        do_write(1, 2'd0, 8'h3F, 32'h0000A53F);
        do_write(2, 2'd0, 8'h41, 32'h00000041);
        do_write(3, 2'd0, 8'h6C, 32'h0000006C);
        do_read(0, 2'd0, 8'h5D);
        do_read(1, 2'd0, 8'h3F);
        do_read(2, 2'd0, 8'h41);
        do_read(3, 2'd0, 8'h6C);

        send_cmd(addrs[0], 1'b1, 2'd0);
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        check("midrd_bit1", 32'(&tx), 32'd0);
        @(negedge clk);
        check("midrd_en", 32'(tx_en), 32'd1);
        rst = 1'b1;
        sel = 1'b0;
        @(negedge clk);
        check("midrd_tx", 32'(tx), 32'hF);
        check("midrd_tx_en", 32'(tx_en), 32'd0);
        check("midrd_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) check("midrd_regs", reg_out[k], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_write(0, 2'd1, 8'h96, 32'h00009600);
        do_read(0, 2'd1, 8'h96);

`ifdef SERIAL_REGFILE_PARITY_EN
        @(negedge clk);
        check("par_clear", 32'(pe), 32'd0);
        bd = 8'h5D;
        send_cmd(addrs[0], 1'b0, 2'd2);
        @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = bd[i];
        end
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        check("par_err", 32'(pe), 32'd1);
        check("par_nostrobe", 32'(wr), 32'd0);
        check("par_nocommit", reg_out[0], 32'h00009600);
        sel = 1'b0;
        @(negedge clk);
        do_write(0, 2'd2, 8'h5D, 32'h005D9600);
        check("par_sticky", 32'(pe), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
